// File: rtl/ssd_scan_multi.sv
// Multi-digit seven-segment scan controller: blanking gap, per-digit
// enable, PWM duty and frame-synchronous shadow update.
//
// Ports:
//   clk_s, rst_s      clock, synchronous active-high reset
//   seg_in            DIGITS active-low segment bytes (digit d at [8d+7:8d])
//   load              capture seg_in; applied at the next frame boundary
//   digit_en          live per-digit enable
//   brightness        duty code, latched at frame boundaries
//   sout_s            registered shared segment bus, active-low
//   anode_s           registered one-cold anodes, active-low
//   frame_done        registered pulse for the last cycle of each frame
module ssd_scan_multi #(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 8000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BRIGHT_W     = 4
) (
  input  logic                  clk_s,
  input  logic                  rst_s,
  input  logic [8*DIGITS-1:0]   seg_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            sout_s,
  output logic [DIGITS-1:0]     anode_s,
  output logic                  frame_done
);

  localparam int DRIVE = SLOT_CYCLES - BLANK_CYCLES;
  localparam int SW    = $clog2(SLOT_CYCLES);
  localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Wide enough for DRIVE * 2^BRIGHT_W and for BLANK + ON_LEN.
  localparam int PW    = $clog2(SLOT_CYCLES + 1) + BRIGHT_W + 1;

  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [8*DIGITS-1:0]   shadow_q, shadow_d;
  logic [8*DIGITS-1:0]   pend_q, pend_d;
  logic                  pflag_q, pflag_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  logic [7:0]            sout_q, sout_d;
  logic [DIGITS-1:0]     anode_q, anode_d;
  logic                  fdone_q, fdone_d;

  logic                  slot_wrap;
  logic                  dig_last;
  logic                  boundary;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         on_len;
  logic [PW-1:0]         c_ext;
  logic                  in_win;
  logic                  lit;
  logic [7:0]            cur_byte;

  assign slot_wrap = (slot_q == SW'(SLOT_CYCLES - 1));
  assign dig_last  = (dig_q == DW'(DIGITS - 1));
  assign boundary  = slot_wrap && dig_last;

  // Counters
  always_comb begin
    slot_d = slot_q + SW'(1);
    dig_d  = dig_q;
    if (slot_wrap) begin
      slot_d = '0;
      dig_d  = dig_last ? '0 : dig_q + DW'(1);
    end
  end

  // Pending capture and frame-boundary shadow/brightness update.
  // A load in the boundary cycle bypasses pend and lands in shadow.
  always_comb begin
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    shadow_d = shadow_q;
    bright_d = bright_q;
    if (load) begin
      pend_d  = seg_in;
      pflag_d = 1'b1;
    end
    if (boundary) begin
      bright_d = brightness;
      pflag_d  = 1'b0;
      if (load)
        shadow_d = seg_in;
      else if (pflag_q)
        shadow_d = pend_q;
    end
  end

  // Drive window within the slot
  always_comb begin
    prod   = PW'(DRIVE) * (PW'(bright_q) + PW'(1));
    on_len = prod >> BRIGHT_W;
    c_ext  = PW'(slot_q);
    in_win = (c_ext >= PW'(BLANK_CYCLES)) &&
             (c_ext <  PW'(BLANK_CYCLES) + on_len);
  end

  always_comb begin
    cur_byte = 8'hFF;
    lit      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == DW'(i)) begin
        cur_byte = shadow_q[8*i +: 8];
        lit      = in_win && digit_en[i];
      end
    end
  end

  always_comb begin
    anode_d = '1;
    for (int i = 0; i < DIGITS; i++)
      anode_d[i] = ~(lit && (dig_q == DW'(i)));
    sout_d  = lit ? cur_byte : 8'hFF;
    fdone_d = boundary;
  end

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      slot_q   <= '0;
      dig_q    <= '0;
      shadow_q <= '1;
      pend_q   <= '1;
      pflag_q  <= 1'b0;
      bright_q <= '1;
      sout_q   <= 8'hFF;
      anode_q  <= '1;
      fdone_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      dig_q    <= dig_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      bright_q <= bright_d;
      sout_q   <= sout_d;
      anode_q  <= anode_d;
      fdone_q  <= fdone_d;
    end
  end

  assign sout_s     = sout_q;
  assign anode_s    = anode_q;
  assign frame_done = fdone_q;

endmodule
